event_gate: RTL

EVENT_GATE -- requirements
Module: event_gate

---
 rtl/event_gate.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/event_gate.sv
// event_gate: synchronizes and debounces event_in, and gates accepted edges into fixed-length windows.
// Define EVENT_GATE_BOTH_EDGES_EN to also count accepted falling edges.
module event_gate #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GATE_CYCLES     = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic event_in,
  output logic increment,
  output logic trigger,
  output logic level
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } db_state_t;

  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  STAB_MAX  = 8'hFF;
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  // Synchronizer chain
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], event_in};
    end
  end

  assign sample = sync_reg[SYNC_STAGES-1];

  // Debouncer
  db_state_t  state_reg, state_next;
  logic [7:0] stab_reg, stab_next;
  logic       level_reg, level_next;
  logic       rise_cand;
`ifdef EVENT_GATE_BOTH_EDGES_EN
  logic       fall_cand;
`endif
  logic       cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= STABLE_LOW;
      stab_reg  <= '0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      stab_reg  <= stab_next;
      level_reg <= level_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stab_next  = stab_reg;
    rise_cand  = 1'b0;
`ifdef EVENT_GATE_BOTH_EDGES_EN
    fall_cand  = 1'b0;
`endif
    case (state_reg)
      STABLE_LOW: begin
        if (sample) begin
          state_next = CHECK_HIGH;
          stab_next  = '0;
        end
      end
      CHECK_HIGH: begin
        if (!sample) begin
          state_next = STABLE_LOW;
          stab_next  = '0;
        end else if (stab_reg == DB_LAST) begin
          state_next = STABLE_HIGH;
          stab_next  = '0;
          rise_cand  = 1'b1;
        end else if (stab_reg != STAB_MAX) begin
          stab_next = stab_reg + 8'd1;
        end
      end
      STABLE_HIGH: begin
        if (!sample) begin
          state_next = CHECK_LOW;
          stab_next  = '0;
        end
      end
      CHECK_LOW: begin
        if (sample) begin
          state_next = STABLE_HIGH;
          stab_next  = '0;
        end else if (stab_reg == DB_LAST) begin
          state_next = STABLE_LOW;
          stab_next  = '0;
`ifdef EVENT_GATE_BOTH_EDGES_EN
          fall_cand  = 1'b1;
`endif
        end else if (stab_reg != STAB_MAX) begin
          stab_next = stab_reg + 8'd1;
        end
      end
      default: begin
        state_next = STABLE_LOW;
        stab_next  = '0;
      end
    endcase
    level_next = (state_next == STABLE_HIGH) || (state_next == CHECK_LOW);
  end

`ifdef EVENT_GATE_BOTH_EDGES_EN
  assign cand = rise_cand | fall_cand;
`else
  assign cand = rise_cand;
`endif

  // Gate timer: run_reg delays counting by one cycle so value GATE_CYCLES-1 lands on the
  // GATE_CYCLES-1'th edge after enable is first seen, putting trigger on the GATE_CYCLES'th.
  logic [31:0] gate_reg, gate_next;
  logic        run_reg;
  logic        trigger_reg, trigger_next;
  logic        increment_reg, increment_next;
  logic        pending_reg, pending_next;

  always_comb begin
    gate_next      = '0;
    trigger_next   = 1'b0;
    increment_next = 1'b0;
    pending_next   = 1'b0;
    if (enable) begin
      if (run_reg && (gate_reg != GATE_LAST)) begin
        gate_next = gate_reg + 32'd1;
      end
      trigger_next = run_reg && (gate_reg == GATE_LAST);
      // The downstream counter favours increment, so a candidate on a trigger cycle waits one cycle.
      if (trigger_next) begin
        pending_next = pending_reg | cand;
      end else begin
        increment_next = pending_reg | cand;
        pending_next   = pending_reg & cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_reg      <= '0;
      run_reg       <= 1'b0;
      trigger_reg   <= 1'b0;
      increment_reg <= 1'b0;
      pending_reg   <= 1'b0;
    end else begin
      gate_reg      <= gate_next;
      run_reg       <= enable;
      trigger_reg   <= trigger_next;
      increment_reg <= increment_next;
      pending_reg   <= pending_next;
    end
  end

  assign increment = increment_reg;
  assign trigger   = trigger_reg;
  assign level     = level_reg;

endmodule
